zpu_mem_responder: RTL and testbench
====================================

// Module: zpu_mem_responder
// PURPOSE
//  Memory-side responder for the zpu_core memory port. Serves single-word read/write requests
//  from the core out of an internal word-organised RAM, with big-endian byte-lane write masking.
//  Inserts a configurable number of wait states and drives the busy handshake the core samples.
//  Sits between zpu_core and on-chip block RAM; also replaces the constant-data stub used in
//  core benches.
// PARAMETERS
//  ADDR_WIDTH     16            width of byte address from core
//  MEM_WORDS_LOG2 12            log2 of RAM depth in 32-bit words (4096 words = 16 KiB)
//  WAIT_STATES    1             busy cycles per access, 0..15
//  INIT_WORD      32'h0b0b0b0b  simulation-time fill value of every RAM word (ZPU nop x4)
//  WATCH_ADDR     16'h0000      byte address monitored when ZPU_MEM_WATCH_EN is defined
// PORTS
//  clk              in   1   system clock, all logic on rising edge
//  reset            in   1   synchronous, active-high
//  mem_addr         in   ADDR_WIDTH  byte address from core; bits [1:0] ignored
//  mem_writeEnable  in   1   write request strobe
//  mem_readEnable   in   1   read request strobe
//  mem_write        in   32  write data
//  mem_writeMask    in   4   byte lane enables; bit3->[31:24] .. bit0->[7:0]
//  mem_read         out  32  registered read data
//  mem_busy         out  1   high while an accepted access is in progress
//  err              out  1   sticky protocol-error flag
//  watch_hit        out  1   one-cycle pulse on write to WATCH_ADDR (macro only)
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE, mem_read=0, mem_busy=0, err=0, watch_hit=0,
//    wait counter=0. RAM contents are not cleared. Reset wins over any same-cycle request.
//  - Word index = mem_addr[MEM_WORDS_LOG2+1:2]; upper address bits ignored (aliasing/wrap).
//  - FSM: IDLE, WAIT, ACCESS.
//    IDLE: request = readEnable|writeEnable sampled high. Latch addr/data/mask/kind.
//      WAIT_STATES==0 -> go to ACCESS with mem_busy kept 0.
//      else -> WAIT, mem_busy=1 from next cycle, counter=WAIT_STATES-1.
//    WAIT: mem_busy=1; decrement counter; at 0 go to ACCESS.
//    ACCESS: perform RAM op, mem_busy=0, return to IDLE. A request sampled here is accepted
//      (IDLE rules apply) so back-to-back accesses cost WAIT_STATES+1 cycles each.
//  - Latency: read data valid on mem_read WAIT_STATES+1 cycles after request cycle, coincident
//    with mem_busy falling; held until the next read completes (writes do not alter mem_read).
//  - Write: only lanes with mask bit set updated; mask 4'b0000 is a legal no-op write.
//  - Read and write strobes both high: treated as write; err set.
//  - Any strobe high while in WAIT: ignored, err set. err clears only on reset.
//  - Reset mid-WAIT: access aborted, RAM not written, mem_read forced to 0.
//  - Read of a word written by the immediately preceding access returns the new data.
// CONFIGURATION
//  ZPU_MEM_WATCH_EN defined: watch_hit pulses high for one cycle in the ACCESS cycle of any
//    write whose word index equals that of WATCH_ADDR with nonzero mask (core break/debug hook).
//  Not defined: watch_hit tied to 0, comparator and WATCH_ADDR logic not built.
// TESTING
//  1 reset, then read addr 16'h0040, WAIT_STATES=1 -> busy high 1 cycle, mem_read=32'h0b0b0b0b
//    on busy fall; mem_read=0 and busy=0 during reset.
//  2 write 32'hdeadbeef mask 4'b1111 to 16'h0100, read back -> 32'hdeadbeef; then mask 4'b0100
//    data 32'h00550000 -> read returns 32'hde55beef.
//  3 WAIT_STATES=0: read strobes on consecutive accesses -> busy never asserted, data 1 cycle
//    after each request; addr 16'h4100 with MEM_WORDS_LOG2=12 aliases to 16'h0100.
//  4 strobe readEnable while busy, WAIT_STATES=3 -> ignored, err=1 and stays 1 until reset;
//    both strobes at once in IDLE -> write performed, err=1.
//  5 assert reset in WAIT of a write to 16'h0200 -> word still 32'h0b0b0b0b on later read.
//  6 ZPU_MEM_WATCH_EN, WATCH_ADDR=16'h0010: write 16'h0012 mask 4'b0001 -> watch_hit one-cycle
//    pulse; write mask 4'b0000 -> no pulse; macro undefined -> watch_hit always 0.

Source files
------------

// File: rtl/zpu_mem_responder.sv
// Memory-side responder for the zpu_core memory port: word RAM with byte-lane writes and wait states.
// Optional write-watch hook built only when ZPU_MEM_WATCH_EN is defined.

module zpu_mem_lane #(
  parameter int         DEPTH_LOG2 = 12,
  parameter logic [7:0] INIT_BYTE  = 8'h0b
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  // Bytes are stored XORed with INIT_BYTE so a zero power-up array reads back as INIT_BYTE.
  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata ^ INIT_BYTE;
    if (reset)      rdata <= 8'h00;
    else if (rd_en) rdata <= mem[idx] ^ INIT_BYTE;
  end
endmodule

module zpu_mem_responder #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    MEM_WORDS_LOG2 = 12,
  parameter int                    WAIT_STATES    = 1,
  parameter logic [31:0]           INIT_WORD      = 32'h0b0b0b0b,
  parameter logic [ADDR_WIDTH-1:0] WATCH_ADDR     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_writeEnable,
  input  logic                  mem_readEnable,
  input  logic [31:0]           mem_write,
  input  logic [3:0]            mem_writeMask,
  output logic [31:0]           mem_read,
  output logic                  mem_busy,
  output logic                  err,
  output logic                  watch_hit
);
  localparam int          NUM_LANES = 4;
  localparam int          IDX_W     = MEM_WORDS_LOG2;
  localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [31:0]          data;
    logic [NUM_LANES-1:0] mask;
    logic                 wr;
  } req_t;

  state_t     state;
  logic [3:0] cnt;
  req_t       req_q, new_req, op;
  logic       strobe, accept, fire_now, fire_wait, fire;
  logic [NUM_LANES-1:0]      lane_wr;
  logic                      lane_rd;
  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic                      unused_bits;

  assign unused_bits = ^{mem_addr, WATCH_ADDR};

  assign strobe  = mem_readEnable | mem_writeEnable;
  assign accept  = strobe && (state != S_WAIT);
  // Both strobes together resolve to a write.
  assign new_req = '{idx: mem_addr[IDX_W+1:2], data: mem_write, mask: mem_writeMask,
                     wr: mem_writeEnable};

  // The RAM op lands on the edge that enters ACCESS, so its result is visible in the ACCESS cycle.
  assign fire_now  = accept && (WAIT_STATES == 0);
  assign fire_wait = (state == S_WAIT) && (cnt == 4'd0);
  assign fire      = !reset && (fire_now || fire_wait);
  assign op        = fire_now ? new_req : req_q;
  assign lane_wr   = (fire && op.wr) ? op.mask : '0;
  assign lane_rd   = fire && !op.wr;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    zpu_mem_lane #(
      .DEPTH_LOG2 (IDX_W),
      .INIT_BYTE  (INIT_WORD[i*8 +: 8])
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr_en (lane_wr[i]),
      .rd_en (lane_rd),
      .idx   (op.idx),
      .wdata (op.data[i*8 +: 8]),
      .rdata (rd_lanes[i])
    );
  end

  assign mem_read = rd_lanes;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      mem_busy <= 1'b0;
      err      <= 1'b0;
      req_q    <= '0;
    end else begin
      case (state)
        S_IDLE, S_ACCESS: begin
          if (accept) begin
            req_q <= new_req;
            if (WAIT_STATES == 0) begin
              state    <= S_ACCESS;
              mem_busy <= 1'b0;
            end else begin
              state    <= S_WAIT;
              mem_busy <= 1'b1;
              cnt      <= CNT_INIT;
            end
          end else begin
            state    <= S_IDLE;
            mem_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state    <= S_ACCESS;
            mem_busy <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          mem_busy <= 1'b0;
        end
      endcase
      if ((strobe && state == S_WAIT) || (accept && mem_readEnable && mem_writeEnable))
        err <= 1'b1;
    end
  end

`ifdef ZPU_MEM_WATCH_EN
  logic watch_match;
  assign watch_match = op.wr && (|op.mask) && (op.idx == WATCH_ADDR[IDX_W+1:2]);

  always_ff @(posedge clk) begin
    if (reset) watch_hit <= 1'b0;
    else       watch_hit <= fire && watch_match;
  end
`else
  assign watch_hit = 1'b0;
`endif

endmodule

// File: tb/tb_zpu_mem_responder.sv
// Directed bench for zpu_mem_responder: three instances (0, 1 and 3 wait states) on shared stimulus.
module tb_zpu_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        we, re;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] rd0, rd1, rd3;
  logic        b0, b1, b3, e0, e1, e3, w0, w1, w3;
  int          total = 0;
  int          bad = 0;

`ifdef ZPU_MEM_WATCH_EN
  localparam logic WATCH_ON = 1'b1;
`else
  localparam logic WATCH_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  zpu_mem_responder #(.WAIT_STATES(0), .WATCH_ADDR(16'h0010)) u0 (
    .clk(clk), .reset(reset), .mem_addr(addr), .mem_writeEnable(we), .mem_readEnable(re),
    .mem_write(wdata), .mem_writeMask(mask), .mem_read(rd0), .mem_busy(b0), .err(e0),
    .watch_hit(w0));
  zpu_mem_responder #(.WAIT_STATES(1), .WATCH_ADDR(16'h0010)) u1 (
    .clk(clk), .reset(reset), .mem_addr(addr), .mem_writeEnable(we), .mem_readEnable(re),
    .mem_write(wdata), .mem_writeMask(mask), .mem_read(rd1), .mem_busy(b1), .err(e1),
    .watch_hit(w1));
  zpu_mem_responder #(.WAIT_STATES(3), .WATCH_ADDR(16'h0010)) u3 (
    .clk(clk), .reset(reset), .mem_addr(addr), .mem_writeEnable(we), .mem_readEnable(re),
    .mem_write(wdata), .mem_writeMask(mask), .mem_read(rd3), .mem_busy(b3), .err(e3),
    .watch_hit(w3));

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one request for a single edge, then drop the strobes.
  task automatic req(input logic w, input logic r, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    we = w; re = r; addr = a; wdata = d; mask = m;
    tick();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_read();
    req(1'b0, 1'b1, 16'h0040, 32'h0, 4'h0);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL read_busy_hi: got %b want 1", b1); end
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL read_early: got %h want 00000000", rd1); end
    total++; if (rd0 !== 32'h0b0b0b0b) begin bad++; $display("FAIL read_ws0: got %h want 0b0b0b0b", rd0); end
    tick();
    total++; if (b1 !== 1'b0) begin bad++; $display("FAIL read_busy_lo: got %b want 0", b1); end
    total++; if (rd1 !== 32'h0b0b0b0b) begin bad++; $display("FAIL read_init: got %h want 0b0b0b0b", rd1); end
  endtask

  task automatic test_reset();
    reset = 1'b1; re = 1'b1; addr = 16'h0040;
    tick();
    re = 1'b0;
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h want 00000000", rd1); end
    total++; if (b1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", b1); end
    total++; if (e1 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", e1); end
    total++; if (w1 !== 1'b0) begin bad++; $display("FAIL reset_watch: got %b want 0", w1); end
    reset = 1'b0;
    tick();
    total++; if (b1 !== 1'b0) begin bad++; $display("FAIL reset_wins: got busy %b want 0", b1); end
  endtask

  task automatic test_write_mask();
    req(1'b1, 1'b0, 16'h0100, 32'hdeadbeef, 4'b1111);
    tick();
    req(1'b0, 1'b1, 16'h0100, 32'h0, 4'h0);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", b1); end
    tick();
    total++; if (rd1 !== 32'hdeadbeef) begin bad++; $display("FAIL wr_full: got %h want deadbeef", rd1); end
    req(1'b1, 1'b0, 16'h0100, 32'h00550000, 4'b0100);
    tick();
    total++; if (rd1 !== 32'hdeadbeef) begin bad++; $display("FAIL wr_hold_rd: got %h want deadbeef", rd1); end
    req(1'b0, 1'b1, 16'h0100, 32'h0, 4'h0);
    tick();
    total++; if (rd1 !== 32'hde55beef) begin bad++; $display("FAIL wr_lane: got %h want de55beef", rd1); end
  endtask

  task automatic test_ws0();
    pulse_reset();
    req(1'b1, 1'b0, 16'h0100, 32'h12345678, 4'b1111);
    total++; if (b0 !== 1'b0) begin bad++; $display("FAIL ws0_busy_w: got %b want 0", b0); end
    req(1'b0, 1'b1, 16'h4100, 32'h0, 4'h0);
    total++; if (rd0 !== 32'h12345678) begin bad++; $display("FAIL ws0_alias: got %h want 12345678", rd0); end
    total++; if (b0 !== 1'b0) begin bad++; $display("FAIL ws0_busy_r1: got %b want 0", b0); end
    req(1'b0, 1'b1, 16'h0040, 32'h0, 4'h0);
    total++; if (rd0 !== 32'h0b0b0b0b) begin bad++; $display("FAIL ws0_r2: got %h want 0b0b0b0b", rd0); end
    total++; if (b0 !== 1'b0) begin bad++; $display("FAIL ws0_busy_r2: got %b want 0", b0); end
    req(1'b0, 1'b1, 16'h0100, 32'h0, 4'h0);
    total++; if (rd0 !== 32'h12345678) begin bad++; $display("FAIL ws0_r3: got %h want 12345678", rd0); end
  endtask

  task automatic test_err();
    pulse_reset();
    req(1'b0, 1'b1, 16'h0040, 32'h0, 4'h0);
    total++; if (b3 !== 1'b1) begin bad++; $display("FAIL err_busy1: got %b want 1", b3); end
    total++; if (e3 !== 1'b0) begin bad++; $display("FAIL err_pre: got %b want 0", e3); end
    req(1'b0, 1'b1, 16'h0100, 32'h0, 4'h0);
    total++; if (e3 !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", e3); end
    total++; if (b3 !== 1'b1) begin bad++; $display("FAIL err_busy2: got %b want 1", b3); end
    tick();
    total++; if (b3 !== 1'b1) begin bad++; $display("FAIL err_busy3: got %b want 1", b3); end
    tick();
    total++; if (b3 !== 1'b0) begin bad++; $display("FAIL err_busy_lo: got %b want 0", b3); end
    total++; if (rd3 !== 32'h0b0b0b0b) begin bad++; $display("FAIL err_rd: got %h want 0b0b0b0b", rd3); end
    tick();
    total++; if (b3 !== 1'b0) begin bad++; $display("FAIL err_ignored: got busy %b want 0", b3); end
    total++; if (e3 !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", e3); end
    pulse_reset();
    total++; if (e3 !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", e3); end
    req(1'b1, 1'b1, 16'h0300, 32'hcafef00d, 4'b1111);
    total++; if (e1 !== 1'b1) begin bad++; $display("FAIL both_err: got %b want 1", e1); end
    tick();
    req(1'b0, 1'b1, 16'h0300, 32'h0, 4'h0);
    tick();
    total++; if (rd1 !== 32'hcafef00d) begin bad++; $display("FAIL both_write: got %h want cafef00d", rd1); end
  endtask

  task automatic test_abort();
    pulse_reset();
    req(1'b0, 1'b1, 16'h0040, 32'h0, 4'h0);
    tick();
    total++; if (rd1 !== 32'h0b0b0b0b) begin bad++; $display("FAIL abort_pre: got %h want 0b0b0b0b", rd1); end
    req(1'b1, 1'b0, 16'h0200, 32'h11223344, 4'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL abort_rd: got %h want 00000000", rd1); end
    total++; if (b1 !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", b1); end
    req(1'b0, 1'b1, 16'h0200, 32'h0, 4'h0);
    tick();
    total++; if (rd1 !== 32'h0b0b0b0b) begin bad++; $display("FAIL abort_ram: got %h want 0b0b0b0b", rd1); end
  endtask

  task automatic test_watch();
    pulse_reset();
    req(1'b1, 1'b0, 16'h0012, 32'h000000aa, 4'b0001);
    total++; if (w1 !== 1'b0) begin bad++; $display("FAIL watch_wait: got %b want 0", w1); end
    tick();
    total++; if (w1 !== WATCH_ON) begin bad++; $display("FAIL watch_pulse: got %b want %b", w1, WATCH_ON); end
    tick();
    total++; if (w1 !== 1'b0) begin bad++; $display("FAIL watch_end: got %b want 0", w1); end
    req(1'b1, 1'b0, 16'h0012, 32'h000000bb, 4'b0000);
    tick();
    total++; if (w1 !== 1'b0) begin bad++; $display("FAIL watch_nomask: got %b want 0", w1); end
    req(1'b1, 1'b0, 16'h0020, 32'h000000cc, 4'b1111);
    tick();
    total++; if (w1 !== 1'b0) begin bad++; $display("FAIL watch_other: got %b want 0", w1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; addr = 16'h0; wdata = 32'h0; mask = 4'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_read();
    test_reset();
    test_write_mask();
    test_ws0();
    test_err();
    test_abort();
    test_watch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
